// File: rtl/axi_rd_pkg.sv
// Shared AXI3 definitions for the read and write engines.
// Burst/size encodings, engine state constants and AR field bundle.
package axi_rd_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [3:0] AXI_ID_ICACHE   = 4'd0;
    localparam logic [3:0] AXI_ID_DCACHE   = 4'd1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW   = 2'd1,
        WR_W    = 2'd2,
        WR_B    = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_ctl_t;

    // AXI arlen for one full cache line of 32-bit words
    function automatic logic [7:0] line_len(input int bytes);
        return 8'(bytes / 4 - 1);
    endfunction

endpackage

// File: rtl/axi_rd_if.sv
// AXI3 read-address and read-data channels.
// master drives AR and rready; slave drives arready and R.
interface axi_rd_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_mux.sv
// One-hot AND-OR multiplexer.
// sel must be one-hot; an all-zero sel yields zero.
module axi_rd_mux #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic [N-1:0]        sel,
    input  logic [N-1:0][W-1:0] din,
    output logic [W-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            dout = dout | (din[k] & {W{sel[k]}});
        end
    end

endmodule

// File: rtl/axi_rd.sv
// AXI3 read engine shared by the i-cache and d-cache.
// One transaction at a time; the d-cache has fixed priority.
module axi_rd
    import axi_rd_pkg::*;
#(
    parameter int D_BYTES_PER_LINE = 16,
    parameter int I_BYTES_PER_LINE = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_rd_req,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,

    input  logic        d_rd_req,
    input  logic        d_rd_burst,
    input  logic [31:0] d_rd_addr,
    input  logic [1:0]  d_rd_size,
    output logic        d_rd_rdy,

    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    output logic        read_unfinish,

    axi_rd_if.master    axi
);

    localparam logic [7:0] D_LEN = line_len(D_BYTES_PER_LINE);
    localparam logic [7:0] I_LEN = line_len(I_BYTES_PER_LINE);

    rd_state_t   state_q;
    rd_state_t   state_d;
    logic        own_d_q;
    logic        burst_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [1:0]  cnt_q;

    logic        idle;
    logic        in_ar;
    logic        in_r;
    logic        accept;
    logic        ar_hs;
    logic        r_hs;
    logic        r_done;
    logic [3:0]  st_sel;
    logic [1:0]  st_raw;

    logic [2:0]  ar_sel;
    ar_ctl_t     ar_d;
    ar_ctl_t     ar_i;
    ar_ctl_t     ar_s;
    logic [$bits(ar_ctl_t)-1:0] ar_raw;
    ar_ctl_t     ar_ctl;

    logic        unused_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            own_d_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                own_d_q <= d_rd_rdy;
                cnt_q   <= 2'd0;
            end else if (r_hs) begin
                cnt_q   <= cnt_q + 2'd1;
            end
        end
    end

    // Request fields are only consumed after an accept, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= d_rd_rdy ? d_rd_addr  : i_rd_addr;
            burst_q <= d_rd_rdy ? d_rd_burst : 1'b1;
            size_q  <= d_rd_rdy ? d_rd_size  : 2'd2;
        end
    end

    always_comb begin
        idle     = (state_q == RD_IDLE);
        in_ar    = (state_q == RD_AR);
        in_r     = (state_q == RD_R);
        d_rd_rdy = idle & ~reset & d_rd_req;
        i_rd_rdy = idle & ~reset & i_rd_req & ~d_rd_req;
        accept   = d_rd_rdy | i_rd_rdy;
        ar_hs    = in_ar & axi.arready;
        r_hs     = in_r & axi.rvalid;
        r_done   = r_hs & axi.rlast;
        st_sel   = {r_done, ar_hs, accept,
                    ~(r_done | ar_hs | accept)};
        ar_sel   = {own_d_q & burst_q, ~own_d_q,
                    own_d_q & ~burst_q};
        ar_d     = '{len: D_LEN, size: AXI_SIZE_WORD,
                     burst: AXI_BURST_INCR};
        ar_i     = '{len: I_LEN, size: AXI_SIZE_WORD,
                     burst: AXI_BURST_INCR};
        ar_s     = '{len: 8'd0, size: {1'b0, size_q},
                     burst: AXI_BURST_FIXED};
    end

    axi_rd_mux #(.W(2), .N(4)) u_st_mux (
        .sel  (st_sel),
        .din  ({RD_IDLE, RD_R, RD_AR, state_q}),
        .dout (st_raw)
    );

    assign state_d = rd_state_t'(st_raw);

    axi_rd_mux #(.W($bits(ar_ctl_t)), .N(3)) u_ar_mux (
        .sel  (ar_sel),
        .din  ({ar_d, ar_i, ar_s}),
        .dout (ar_raw)
    );

    assign ar_ctl = ar_ctl_t'(ar_raw);

    assign axi.arid    = own_d_q ? AXI_ID_DCACHE : AXI_ID_ICACHE;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = ar_ctl.len;
    assign axi.arsize  = ar_ctl.size;
    assign axi.arburst = ar_ctl.burst;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = in_ar;
    assign axi.rready  = in_r;

    assign d_ret_valid = in_r & own_d_q & axi.rvalid;
    assign d_ret_last  = own_d_q & axi.rlast;
    assign d_ret_data  = axi.rdata;
    assign i_ret_valid = in_r & ~own_d_q & axi.rvalid;
    assign i_ret_last  = ~own_d_q & axi.rlast;
    assign i_ret_data  = axi.rdata;

    assign read_unfinish = ~idle | i_rd_req | d_rd_req;

    // rid/rresp are ignored; the beat count never forces termination
    assign unused_ok = ^{axi.rid, axi.rresp, cnt_q};

endmodule

// File: tb/tb_axi_rd.sv
// Directed bench for axi_rd with a scripted AXI read slave.
// i-cache lines are 32 bytes here so i and d arlen differ.
module tb_axi_rd;
    import axi_rd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rd_req;
    logic [31:0] i_rd_addr;
    logic        i_rd_rdy;
    logic        d_rd_req;
    logic        d_rd_burst;
    logic [31:0] d_rd_addr;
    logic [1:0]  d_rd_size;
    logic        d_rd_rdy;
    logic        i_ret_valid;
    logic        i_ret_last;
    logic [31:0] i_ret_data;
    logic        d_ret_valid;
    logic        d_ret_last;
    logic [31:0] d_ret_data;
    logic        read_unfinish;

    axi_rd_if axi ();

    axi_rd #(
        .D_BYTES_PER_LINE (16),
        .I_BYTES_PER_LINE (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_rd_req      (i_rd_req),
        .i_rd_addr     (i_rd_addr),
        .i_rd_rdy      (i_rd_rdy),
        .d_rd_req      (d_rd_req),
        .d_rd_burst    (d_rd_burst),
        .d_rd_addr     (d_rd_addr),
        .d_rd_size     (d_rd_size),
        .d_rd_rdy      (d_rd_rdy),
        .i_ret_valid   (i_ret_valid),
        .i_ret_last    (i_ret_last),
        .i_ret_data    (i_ret_data),
        .d_ret_valid   (d_ret_valid),
        .d_ret_last    (d_ret_last),
        .d_ret_data    (d_ret_data),
        .read_unfinish (read_unfinish),
        .axi           (axi)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int gaps[8];
    bit i_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic clear_gaps();
        for (int k = 0; k < 8; k++) gaps[k] = 0;
    endtask

    // Entered in the low clock phase; returns in the low phase, idle
    task automatic txn(input bit is_d, input bit burst,
                       input logic [31:0] addr, input logic [1:0] size,
                       input int ar_wait, input logic [7:0] e_len,
                       input logic [2:0] e_size, input logic [1:0] e_burst,
                       input int nbeats, input logic [31:0] dbase);
        d_rd_req   = is_d;
        d_rd_burst = burst;
        d_rd_addr  = addr;
        d_rd_size  = size;
        if (!is_d) begin
            i_rd_req  = 1'b1;
            i_rd_addr = addr;
        end
        #1;
        check("d_rdy", d_rd_rdy, 32'(is_d));
        check("i_rdy", i_rd_rdy, 32'(!is_d));
        check("unfin_req", read_unfinish, 1);
        @(negedge clk);
        d_rd_req = 1'b0;
        if (!(is_d && i_hold)) i_rd_req = 1'b0;
        #1;
        check("arvalid", axi.arvalid, 1);
        check("araddr", axi.araddr, addr);
        check("arlen", axi.arlen, e_len);
        check("arsize", axi.arsize, e_size);
        check("arburst", axi.arburst, e_burst);
        check("arid", axi.arid, is_d ? 1 : 0);
        check("ar_zero", {axi.arlock, axi.arcache, axi.arprot}, 0);
        check("rdy_busy", {d_rd_rdy, i_rd_rdy}, 0);
        for (int w = 0; w < ar_wait; w++) begin
            @(negedge clk);
            #1;
            check("ar_hold", axi.arvalid, 1);
            check("ar_addr_hold", axi.araddr, addr);
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        #1;
        check("ar_done", axi.arvalid, 0);
        check("rready", axi.rready, 1);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                check("gap_vld", {d_ret_valid, i_ret_valid}, 0);
                @(negedge clk);
                #1;
            end
            axi.rvalid = 1'b1;
            axi.rdata  = dbase + 32'(b);
            axi.rlast  = (b == nbeats - 1);
            axi.rid    = 4'($urandom_range(0, 15));
            axi.rresp  = 2'b10;
            #1;
            check("own_vld", is_d ? d_ret_valid : i_ret_valid, 1);
            check("oth_vld", is_d ? i_ret_valid : d_ret_valid, 0);
            check("ret_data", is_d ? d_ret_data : i_ret_data,
                  dbase + 32'(b));
            check("ret_last", is_d ? d_ret_last : i_ret_last,
                  32'(b == nbeats - 1));
            check("unfin_beat", read_unfinish, 1);
            check("rdy_in_r", {d_rd_rdy, i_rd_rdy}, 0);
            @(negedge clk);
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            #1;
        end
        check("idle_rready", axi.rready, 0);
        check("idle_arvalid", axi.arvalid, 0);
        check("idle_ret", {d_ret_valid, i_ret_valid}, 0);
        check("unfin_end", read_unfinish, 32'(is_d && i_hold));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        i_rd_req    = 1'b1;
        i_rd_addr   = 32'h0;
        d_rd_req    = 1'b1;
        d_rd_burst  = 1'b0;
        d_rd_addr   = 32'h0;
        d_rd_size   = 2'd0;
        axi.arready = 1'b0;
        axi.rid     = 4'd0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rvalid  = 1'b1;
        clear_gaps();
        #2;
        check("rst_rdy", {d_rd_rdy, i_rd_rdy}, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_ret", {d_ret_valid, i_ret_valid}, 0);
        repeat (2) @(negedge clk);
        i_rd_req   = 1'b0;
        d_rd_req   = 1'b0;
        axi.rvalid = 1'b0;
        reset      = 1'b0;

        // d burst, arready after 2 cycles, beats A0..A3
        txn(1, 1, 32'h1000, 2'd2, 2, 8'd3, 3'd2, 2'b01, 4, 32'hA0);
        // d single, halfword
        txn(1, 0, 32'h2002, 2'd1, 0, 8'd0, 3'd1, 2'b00, 1, 32'h55);
        // d single, byte
        txn(1, 0, 32'h6001, 2'd0, 1, 8'd0, 3'd0, 2'b00, 1, 32'h66);

        // simultaneous requests; i-cache held until d completes
        i_hold    = 1'b1;
        i_rd_req  = 1'b1;
        i_rd_addr = 32'h5000;
        txn(1, 1, 32'h4000, 2'd2, 0, 8'd3, 3'd2, 2'b01, 4, 32'hB0);
        i_hold = 1'b0;
        check("i_rdy_after_d", i_rd_rdy, 1);
        // i burst with rvalid gaps 0,1,3
        gaps[1] = 1;
        gaps[2] = 3;
        gaps[5] = 1;
        txn(0, 1, 32'h5000, 2'd0, 1, 8'd7, 3'd2, 2'b01, 8, 32'hC0);
        clear_gaps();

        // early rlast terminates a d burst after two beats
        txn(1, 1, 32'h7000, 2'd2, 0, 8'd3, 3'd2, 2'b01, 2, 32'hD0);

        // asynchronous reset during beat 2 of a d burst
        d_rd_req   = 1'b1;
        d_rd_burst = 1'b1;
        d_rd_addr  = 32'h3000;
        @(negedge clk);
        d_rd_req    = 1'b0;
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'hE0;
        @(negedge clk);
        axi.rdata = 32'hE1;
        #1;
        check("rst_pre_vld", d_ret_valid, 1);
        d_rd_req = 1'b1;
        i_rd_req = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("arst_rready", axi.rready, 0);
        check("arst_ret", {d_ret_valid, i_ret_valid}, 0);
        check("arst_arvalid", axi.arvalid, 0);
        check("arst_rdy", {d_rd_rdy, i_rd_rdy}, 0);
        axi.rvalid = 1'b0;
        d_rd_req   = 1'b0;
        i_rd_req   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(1, 0, 32'h8004, 2'd2, 0, 8'd0, 3'd2, 2'b00, 1, 32'hF0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
